// File: rtl/cam_pkg.sv
// Shared defaults, helper function and registered search-result type for the cam_ext CAM.
package cam_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_LOG2_DEF = 5;

    // Upper bounds so the helper and the result struct cover any legal depth.
    localparam int MAX_ENTRIES = 1024;
    localparam int MAX_IDX_W   = 10;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] index;
        logic                 multi;
    } search_result_t;

    // Clearing the lowest set bit leaves a nonzero value only if two or more bits were set.
    function automatic logic popcount_ge2(input logic [MAX_ENTRIES-1:0] v);
        logic [MAX_ENTRIES-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (v & (v - one)) != '0;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with any/multi flags; purely combinational.
module cam_prio_enc
    import cam_pkg::*;
#(
    parameter int N     = 32,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit is the last one to write idx.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any   = |vec;
    assign multi = popcount_ge2(MAX_ENTRIES'(vec));

endmodule

// File: rtl/cam_ext.sv
// Parametrised CAM with valid bits, invalidate, priority search and occupancy tracking.
// Optional masked search is enabled with the CAM_MASK_EN macro.
module cam_ext
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic                  read_i,
    input  logic [DEPTH_LOG2-1:0] read_index_i,
    input  logic                  write_i,
    input  logic [DEPTH_LOG2-1:0] write_index_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  invalidate_i,
    input  logic [DEPTH_LOG2-1:0] invalidate_index_i,
    input  logic                  search_i,
    input  logic [DATA_WIDTH-1:0] search_data_i,
`ifdef CAM_MASK_EN
    input  logic [DATA_WIDTH-1:0] search_mask_i,
`endif
    output logic                  read_valid_o,
    output logic [DATA_WIDTH-1:0] read_value_o,
    output logic                  search_valid_o,
    output logic [DEPTH_LOG2-1:0] search_index_o,
    output logic                  search_multi_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2-1:0] free_index_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid_reg, valid_next;
    logic [DEPTH-1:0]      match_vec;
    logic [DEPTH_LOG2:0]   count_reg, count_next;
    logic [DEPTH_LOG2-1:0] free_index_reg, free_index_next;
    logic                  full_reg;
    logic                  read_valid_reg;
    logic [DATA_WIDTH-1:0] read_data_reg;
    search_result_t        search_reg, search_next;

    logic [DEPTH_LOG2-1:0] match_idx, free_idx;
    logic                  match_any, match_multi, free_any, free_multi;
    logic                  count_inc, count_dec;

    // Matching uses pre-update contents, giving read-before-write for searches.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
`ifdef CAM_MASK_EN
            assign match_vec[gi] = valid_reg[gi] &&
                (((mem[gi] ^ search_data_i) & ~search_mask_i) == '0);
`else
            assign match_vec[gi] = valid_reg[gi] && (mem[gi] == search_data_i);
`endif
        end
    endgenerate

    cam_prio_enc #(.N(DEPTH), .IDX_W(DEPTH_LOG2)) u_match_enc (
        .vec   (match_vec),
        .idx   (match_idx),
        .any   (match_any),
        .multi (match_multi)
    );

    cam_prio_enc #(.N(DEPTH), .IDX_W(DEPTH_LOG2)) u_free_enc (
        .vec   (~valid_next),
        .idx   (free_idx),
        .any   (free_any),
        .multi (free_multi)
    );

    always_comb begin
        valid_next = valid_reg;
        if (invalidate_i) begin
            valid_next[invalidate_index_i] = 1'b0;
        end
        // Applied after the invalidate so a same-index write wins.
        if (write_i) begin
            valid_next[write_index_i] = 1'b1;
        end

        count_inc = write_i && !valid_reg[write_index_i];
        count_dec = invalidate_i && valid_reg[invalidate_index_i] &&
                    !(write_i && (write_index_i == invalidate_index_i));

        count_next = count_reg;
        if (count_inc && !count_dec && (count_reg != DEPTH_CNT)) begin
            count_next = count_reg + 1'b1;
        end else if (count_dec && !count_inc && (count_reg != '0)) begin
            count_next = count_reg - 1'b1;
        end

        free_index_next = free_any ? free_idx : '0;

        search_next       = '0;
        search_next.valid = search_i && match_any;
        search_next.index = (search_i && match_any) ? MAX_IDX_W'(match_idx) : '0;
        search_next.multi = search_i && match_multi;
    end

    // Data array carries no reset; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (write_i && !reset_i) begin
            mem[write_index_i] <= write_data_i;
        end
        read_data_reg <= mem[read_index_i];
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            valid_reg      <= '0;
            count_reg      <= '0;
            free_index_reg <= '0;
            full_reg       <= 1'b0;
            read_valid_reg <= 1'b0;
            search_reg     <= '0;
        end else begin
            valid_reg      <= valid_next;
            count_reg      <= count_next;
            free_index_reg <= free_index_next;
            full_reg       <= (count_next == DEPTH_CNT);
            read_valid_reg <= read_i && valid_reg[read_index_i];
            search_reg     <= search_next;
        end
    end

    assign read_valid_o   = read_valid_reg;
    assign read_value_o   = read_valid_reg ? read_data_reg : '0;
    assign search_valid_o = search_reg.valid;
    assign search_index_o = search_reg.index[DEPTH_LOG2-1:0];
    assign search_multi_o = search_reg.multi;
    assign full_o         = full_reg;
    assign free_index_o   = free_index_reg;
    assign count_o        = count_reg;

    logic unused_ok;
    assign unused_ok = free_multi ^ (|search_reg.index);

endmodule

// File: tb/tb_cam_ext.sv
// Directed table-driven bench for cam_ext (32x32 default), with masked-search checks under CAM_MASK_EN.
module tb_cam_ext;

    localparam int DW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          read_i;
    logic [IW-1:0] read_index_i;
    logic          write_i;
    logic [IW-1:0] write_index_i;
    logic [DW-1:0] write_data_i;
    logic          invalidate_i;
    logic [IW-1:0] invalidate_index_i;
    logic          search_i;
    logic [DW-1:0] search_data_i;
    logic [DW-1:0] search_mask_i;
    logic          read_valid_o;
    logic [DW-1:0] read_value_o;
    logic          search_valid_o;
    logic [IW-1:0] search_index_o;
    logic          search_multi_o;
    logic          full_o;
    logic [IW-1:0] free_index_o;
    logic [IW:0]   count_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cam_ext #(.DATA_WIDTH(DW), .DEPTH_LOG2(IW)) dut (
        .clk                (clk),
        .reset_i            (reset_i),
        .read_i             (read_i),
        .read_index_i       (read_index_i),
        .write_i            (write_i),
        .write_index_i      (write_index_i),
        .write_data_i       (write_data_i),
        .invalidate_i       (invalidate_i),
        .invalidate_index_i (invalidate_index_i),
        .search_i           (search_i),
        .search_data_i      (search_data_i),
`ifdef CAM_MASK_EN
        .search_mask_i      (search_mask_i),
`endif
        .read_valid_o       (read_valid_o),
        .read_value_o       (read_value_o),
        .search_valid_o     (search_valid_o),
        .search_index_o     (search_index_o),
        .search_multi_o     (search_multi_o),
        .full_o             (full_o),
        .free_index_o       (free_index_o),
        .count_o            (count_o)
    );

    typedef struct {
        int rd, ridx, wr, widx, wdata, inv, iidx, srch, sdata;
        int e_rv, e_rval, e_sv, e_sidx, e_sm, e_full, e_free, e_cnt;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset_i = 1'b0; read_i = 1'b0; read_index_i = '0;
        write_i = 1'b0; write_index_i = '0; write_data_i = '0;
        invalidate_i = 1'b0; invalidate_index_i = '0;
        search_i = 1'b0; search_data_i = '0; search_mask_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int e_full, input int e_free, input int e_cnt);
        chk({tag, "_full"},  32'(full_o),       32'(e_full));
        chk({tag, "_free"},  32'(free_index_o), 32'(e_free));
        chk({tag, "_count"}, 32'(count_o),      32'(e_cnt));
    endtask

    task automatic chk_search(input string tag, input int e_sv, input int e_sidx, input int e_sm);
        chk({tag, "_sv"},    32'(search_valid_o), 32'(e_sv));
        chk({tag, "_sidx"},  32'(search_index_o), 32'(e_sidx));
        chk({tag, "_multi"}, 32'(search_multi_o), 32'(e_sm));
    endtask

    initial begin
        // rd ridx wr widx wdata inv iidx srch sdata | rv rval sv sidx sm full free cnt
        vecs[0]  = '{0,0, 0,0,0,     0,0, 0,0,     0,0,     0,0,0, 0,0,0};
        vecs[1]  = '{0,0, 1,1,1,     0,0, 0,0,     0,0,     0,0,0, 0,0,1};
        vecs[2]  = '{0,0, 1,3,3,     0,0, 0,0,     0,0,     0,0,0, 0,0,2};
        vecs[3]  = '{0,0, 1,5,5,     0,0, 0,0,     0,0,     0,0,0, 0,0,3};
        vecs[4]  = '{0,0, 1,7,7,     0,0, 0,0,     0,0,     0,0,0, 0,0,4};
        vecs[5]  = '{1,3, 0,0,0,     0,0, 0,0,     1,3,     0,0,0, 0,0,4};
        vecs[6]  = '{1,4, 0,0,0,     0,0, 0,0,     0,0,     0,0,0, 0,0,4};
        vecs[7]  = '{0,0, 1,5,9,     0,0, 1,5,     0,0,     1,5,0, 0,0,4};
        vecs[8]  = '{0,0, 0,0,0,     0,0, 1,5,     0,0,     0,0,0, 0,0,4};
        vecs[9]  = '{0,0, 0,0,0,     0,0, 1,9,     0,0,     1,5,0, 0,0,4};
        vecs[10] = '{0,0, 1,2,'hA,   0,0, 0,0,     0,0,     0,0,0, 0,0,5};
        vecs[11] = '{0,0, 1,6,'hA,   0,0, 0,0,     0,0,     0,0,0, 0,0,6};
        vecs[12] = '{0,0, 0,0,0,     0,0, 1,'hA,   0,0,     1,2,1, 0,0,6};
        vecs[13] = '{0,0, 0,0,0,     1,2, 0,0,     0,0,     0,0,0, 0,0,5};
        vecs[14] = '{0,0, 0,0,0,     0,0, 1,'hA,   0,0,     1,6,0, 0,0,5};
        vecs[15] = '{0,0, 0,0,0,     1,2, 0,0,     0,0,     0,0,0, 0,0,5};
        vecs[16] = '{0,0, 1,0,'h55,  1,1, 0,0,     0,0,     0,0,0, 0,1,5};
        vecs[17] = '{1,1, 0,0,0,     0,0, 0,0,     0,0,     0,0,0, 0,1,5};
        vecs[18] = '{1,1, 1,1,'h77,  0,0, 0,0,     0,0,     0,0,0, 0,2,6};
        vecs[19] = '{1,1, 1,2,'hBB,  1,2, 1,'h77,  1,'h77,  1,1,0, 0,4,7};
        vecs[20] = '{1,2, 0,0,0,     0,0, 0,0,     1,'hBB,  0,0,0, 0,4,7};

        idle();
        reset_i = 1'b1;
        tick();
        tick();
        chk_state("reset", 0, 0, 0);
        chk("reset_rv", 32'(read_valid_o), 32'd0);
        chk_search("reset", 0, 0, 0);
        reset_i = 1'b0;

        for (int i = 0; i < 21; i++) begin
            read_i             = 1'(vecs[i].rd);
            read_index_i       = IW'(vecs[i].ridx);
            write_i            = 1'(vecs[i].wr);
            write_index_i      = IW'(vecs[i].widx);
            write_data_i       = DW'(vecs[i].wdata);
            invalidate_i       = 1'(vecs[i].inv);
            invalidate_index_i = IW'(vecs[i].iidx);
            search_i           = 1'(vecs[i].srch);
            search_data_i      = DW'(vecs[i].sdata);
            search_mask_i      = '0;
            tick();
            chk($sformatf("v%0d_rv", i),   32'(read_valid_o), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_rval", i), read_value_o,      32'(vecs[i].e_rval));
            chk_search($sformatf("v%0d", i), vecs[i].e_sv, vecs[i].e_sidx, vecs[i].e_sm);
            chk_state($sformatf("v%0d", i), vecs[i].e_full, vecs[i].e_free, vecs[i].e_cnt);
        end

        // Fill every entry, checking full only once the last slot is taken.
        idle();
        for (int i = 0; i < 32; i++) begin
            write_i       = 1'b1;
            write_index_i = IW'(i);
            write_data_i  = 32'h100 + 32'(i);
            tick();
            if (i == 30) chk_state("fill31", 0, 31, 31);
        end
        chk_state("filled", 1, 0, 32);

        idle();
        search_i = 1'b1; search_data_i = 32'h105;
        read_i = 1'b1; read_index_i = 5'd5;
        tick();
        chk_search("full_search", 1, 5, 0);
        chk("full_rval", read_value_o, 32'h105);

        idle();
        write_i = 1'b1; write_index_i = 5'd0; write_data_i = 32'hDEAD;
        invalidate_i = 1'b1; invalidate_index_i = 5'd0;
        tick();
        chk_state("wr_inv_same", 1, 0, 32);

        idle();
        read_i = 1'b1; read_index_i = 5'd0;
        tick();
        chk("wr_inv_rv", 32'(read_valid_o), 32'd1);
        chk("wr_inv_rval", read_value_o, 32'hDEAD);

        // Reset overrides a simultaneous write.
        idle();
        reset_i = 1'b1;
        write_i = 1'b1; write_index_i = 5'd9; write_data_i = 32'h105;
        tick();
        chk_state("rst_mid", 0, 0, 0);
        idle();
        search_i = 1'b1; search_data_i = 32'h105;
        read_i = 1'b1; read_index_i = 5'd5;
        tick();
        chk_search("post_rst", 0, 0, 0);
        chk("post_rst_rv", 32'(read_valid_o), 32'd0);
        chk("post_rst_rval", read_value_o, 32'd0);

`ifdef CAM_MASK_EN
        idle();
        write_i = 1'b1; write_index_i = 5'd4; write_data_i = 32'h12345678;
        tick();
        idle();
        search_i = 1'b1; search_data_i = 32'h12340000; search_mask_i = 32'h0000FFFF;
        tick();
        chk_search("mask_hit", 1, 4, 0);
        search_mask_i = 32'h0;
        tick();
        chk_search("mask_zero", 0, 0, 0);
        search_data_i = 32'h0; search_mask_i = 32'hFFFFFFFF;
        tick();
        chk_search("mask_all", 1, 4, 0);
`endif

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_ext.md
Name: cam_ext

Overview:
Parametrised successor to the lab CAM. Adds:
- configurable data width and depth
- per-entry valid bits, an invalidate port, and lowest-index priority search with a multi-hit flag
- free-slot and occupancy tracking

All outputs are registered with 1-cycle latency. It sits as a lookup table beside the datapath and serves one read, one write, one invalidate and one search per cycle.

Parameters:
- DATA_WIDTH, 32, width of stored word and search key
- DEPTH_LOG2, 5, log2 of entry count; DEPTH = 2**DEPTH_LOG2

Ports:
- clk  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- read_i  in  1  read request
- read_index_i  in  DEPTH_LOG2  entry to read
- write_i  in  1  write request
- write_index_i  in  DEPTH_LOG2  entry to write
- write_data_i  in  DATA_WIDTH  data to store
- invalidate_i  in  1  clear valid bit of an entry
- invalidate_index_i  in  DEPTH_LOG2  entry to invalidate
- search_i  in  1  search request
- search_data_i  in  DATA_WIDTH  search key
- search_mask_i  in  DATA_WIDTH  bit=1 means don't-care (present only with CAM_MASK_EN)
- read_valid_o  out  1  read hit a valid entry
- read_value_o  out  DATA_WIDTH  data of read entry
- search_valid_o  out  1  at least one valid entry matched
- search_index_o  out  DEPTH_LOG2  lowest matching index
- search_multi_o  out  1  two or more entries matched
- full_o  out  1  all entries valid
- free_index_o  out  DEPTH_LOG2  lowest invalid index
- count_o  out  DEPTH_LOG2+1  number of valid entries

Behaviour:
- Reset (synchronous, active-high, at the clk edge):
  - valid bits all 0; data array not reset
  - read_valid_o, read_value_o, search_valid_o, search_index_o, search_multi_o, full_o, count_o = 0; free_index_o = 0
- Latency: a request sampled at edge N produces its result on outputs after edge N+1. Outputs hold until the next request.
  - Cycle with read_i=0: read_valid_o=0, read_value_o=0.
  - Cycle with search_i=0: search_valid_o=0, search_index_o=0, search_multi_o=0.
- Read/search ordering: read and search in cycle N see contents before cycle N's write or invalidate (read-before-write). Results of a write in cycle N are visible to requests from cycle N+1.
- read_valid_o = valid[read_index_i]. read_value_o = stored data if valid, else 0.
- Write sets valid[idx] and stores data. A write to an already-valid entry overwrites it; count is unchanged.
- Invalidate clears valid[idx]. Invalidating an invalid entry is a no-op.
- Write and invalidate to the same index in the same cycle: the write wins (entry valid, new data). Different indices: both apply.
- Match rule: valid[i] && (data[i] == search_data_i).
  - search_index_o is the lowest matching index.
  - search_multi_o = 1 when the popcount of matches is >= 2.
  - Duplicates are permitted; the CAM does not prevent them.
- count_o increments by 1 on a write to an invalid entry, decrements by 1 on an effective invalidate, is unchanged if both occur, and saturates at range 0..DEPTH.
- full_o = (count == DEPTH).
- free_index_o is the lowest index with valid=0, registered from post-update state. When full_o=1, free_index_o = 0 (don't care).
- Reset asserted mid-operation overrides all requests in that cycle.

Optional Feature:
Macro CAM_MASK_EN.
- Defined: search_mask_i port exists. Match rule becomes valid[i] && ((data[i] ^ search_data_i) & ~search_mask_i) == 0. An all-ones mask matches every valid entry.
- Undefined: no mask port; exact match only.

Decomposition:
- Package cam_pkg: localparam defaults (DATA_WIDTH, DEPTH_LOG2), function popcount_ge2, and a struct typedef for registered search results {valid, index, multi}.
- One sub-module, cam_prio_enc:
  - parameter N
  - input vector
  - outputs lowest-set index, any, multi
  - combinational
  - reused for search match and free-slot (on ~valid)

Test Plan:
- Reset, then write idx1=0x1, idx3=0x3, idx5=0x5, idx7=0x7 -> count_o=4, free_index_o=0, full_o=0.
- Read idx3 -> next cycle read_valid_o=1, read_value_o=0x3. Read idx4 -> read_valid_o=0, read_value_o=0.
- Same cycle: search 0x5 and write idx5=0x9 -> search_valid_o=1, search_index_o=5. Next-cycle search 0x5 -> search_valid_o=0; search 0x9 -> index 5.
- Write 0xA to idx2 and idx6, then search 0xA -> search_index_o=2, search_multi_o=1. Invalidate idx2, search 0xA -> index 6, multi=0.
- Fill all 32 entries -> full_o=1, count_o=32. Write and invalidate idx0 in the same cycle -> entry valid, count_o=32. Assert reset_i -> count_o=0, search of any value misses.
- With CAM_MASK_EN: store 0x12345678 at idx4, search 0x12340000 with mask 0x0000FFFF -> hit index 4; mask 0 -> miss.
